// File: rtl/led_pwm_core.sv
// Soft RGB PWM / blink / breathe engine with an 8-bit register-write interface.
// Replaces the hard LEDDA primitive; all outputs are registered.
module led_pwm_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       exe,
    output logic [2:0] pwm_out,
    output logic       led_on
);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } blink_t;

    localparam logic [3:0] A_DUTYR  = 4'h0;
    localparam logic [3:0] A_DUTYG  = 4'h1;
    localparam logic [3:0] A_DUTYB  = 4'h2;
    localparam logic [3:0] A_PRESCL = 4'h3;
    localparam logic [3:0] A_PRESCH = 4'h4;
    localparam logic [3:0] A_ONR    = 4'h5;
    localparam logic [3:0] A_OFR    = 4'h6;
    localparam logic [3:0] A_BCR    = 4'h7;
    localparam logic [3:0] A_STATUS = 4'h8;

    // Register file
    logic [2:0][7:0] duty;
    logic [9:0]      presc;
    logic [7:0]      onr;
    logic [7:0]      ofr;
    logic            bre_en;
    logic [3:0]      step;

    // Engine state
    logic [9:0]      pcnt;
    logic [7:0]      cnt;
    logic [7:0]      fcnt;
    logic [7:0]      b;
    logic [2:0][7:0] eff;
    blink_t          state;

    // Next-period values, consumed only at a period end
    blink_t          state_nx;
    logic [7:0]      fcnt_nx;
    logic [7:0]      b_nx;
    logic [2:0][7:0] eff_nx;
    logic [8:0]      fcnt_inc;
    logic [8:0]      b_sum;
    logic [7:0]      rd_data;

    logic tick;
    logic pe;
    logic wr_en;
    logic rd_en;

    assign wr_en = cs & we;
    assign rd_en = cs & ~we;
    assign tick  = (pcnt >= presc);
    assign pe    = tick && (cnt == 8'hFF);

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    // NOTE: register contents are architecturally visible and must read 0x00
    // after reset, so this small register file is reset unlike a RAM would be.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty   <= '0;
            presc  <= '0;
            onr    <= '0;
            ofr    <= '0;
            bre_en <= 1'b0;
            step   <= '0;
        end else if (wr_en) begin
            case (addr)
                A_DUTYR:  duty[0]     <= din;
                A_DUTYG:  duty[1]     <= din;
                A_DUTYB:  duty[2]     <= din;
                A_PRESCL: presc[7:0]  <= din;
                A_PRESCH: presc[9:8]  <= din[1:0];
                A_ONR:    onr         <= din;
                A_OFR:    ofr         <= din;
                A_BCR: begin
                    bre_en <= din[7];
                    step   <= din[3:0];
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register reads, one cycle of latency
    // ------------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            A_DUTYR:  rd_data = duty[0];
            A_DUTYG:  rd_data = duty[1];
            A_DUTYB:  rd_data = duty[2];
            A_PRESCL: rd_data = presc[7:0];
            A_PRESCH: rd_data = {6'b0, presc[9:8]};
            A_ONR:    rd_data = onr;
            A_OFR:    rd_data = ofr;
            A_BCR:    rd_data = {bre_en, 3'b0, step};
            A_STATUS: rd_data = {6'b0, (b != 8'h00), led_on};
            default:  rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= 8'h00;
        end else if (rd_en) begin
            dout <= rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Period-end decisions: blink state, breathe level, effective duties
    // ------------------------------------------------------------------
    always_comb begin
        fcnt_inc = {1'b0, fcnt} + 9'd1;
        state_nx = state;
        fcnt_nx  = fcnt_inc[7:0];

        if (state == ST_ON) begin
            if ((ofr != 8'h00) && (fcnt_inc >= {1'b0, onr})) begin
                state_nx = ST_OFF;
                fcnt_nx  = 8'h00;
            end
        end else begin
            if ((onr != 8'h00) && (fcnt_inc >= {1'b0, ofr})) begin
                state_nx = ST_ON;
                fcnt_nx  = 8'h00;
            end
        end

        // Breathe level ramps toward 255 while ON and toward 0 while OFF
        b_sum = {1'b0, b} + {5'b0, step};
        if (state_nx == ST_ON) begin
            b_nx = b_sum[8] ? 8'hFF : b_sum[7:0];
        end else begin
            b_nx = (b > {4'b0, step}) ? (b - {4'b0, step}) : 8'h00;
        end

        eff_nx = '0;
        for (int i = 0; i < 3; i++) begin
            if (bre_en) begin
                eff_nx[i] = 8'((16'(duty[i]) * 16'(b_nx)) >> 8);
            end else if (state_nx == ST_ON) begin
                eff_nx[i] = duty[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler, PWM counter, blink FSM and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, matching the flops that get built.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt    <= '0;
            cnt     <= '0;
            fcnt    <= '0;
            b       <= '0;
            eff     <= '0;
            state   <= ST_OFF;
            pwm_out <= '0;
            led_on  <= 1'b0;
        end else if (!exe) begin
            // cnt parked at 255 makes the first tick after exe rises a period end
            pcnt    <= '0;
            cnt     <= 8'hFF;
            fcnt    <= '0;
            b       <= '0;
            eff     <= '0;
            state   <= ((onr == 8'h00) && (ofr != 8'h00)) ? ST_OFF : ST_ON;
            pwm_out <= '0;
            led_on  <= 1'b0;
        end else begin
            pcnt <= tick ? 10'd0 : pcnt + 10'd1;
            if (tick) begin
                cnt <= cnt + 8'd1;
            end
            if (pe) begin
                state <= state_nx;
                fcnt  <= fcnt_nx;
                b     <= b_nx;
                eff   <= eff_nx;
            end
            for (int i = 0; i < 3; i++) begin
                pwm_out[i] <= (cnt < eff[i]);
            end
            led_on <= (state == ST_ON);
        end
    end

endmodule

// File: tb/tb_led_pwm_core.sv
// Directed self-checking bench for led_pwm_core: bus access, PWM duty and
// prescale, blink timing, breathe ramp, exe gating and asynchronous reset.
module tb_led_pwm_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       exe = 1'b0;
    logic [2:0] pwm_out;
    logic       led_on;

    int checks = 0;
    int errors = 0;

    led_pwm_core dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .exe     (exe),
        .pwm_out (pwm_out),
        .led_on  (led_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic start_exe();
        @(negedge clk);
        exe = 1'b1;
    endtask

    task automatic stop_exe();
        @(negedge clk);
        exe = 1'b0;
    endtask

    // Samples n negedges: high counts per output and rising edges of red
    task automatic meas(input int n, output int hr, output int hg, output int hb,
                        output int hl, output int rr);
        logic prev;
        hr = 0; hg = 0; hb = 0; hl = 0; rr = 0; prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hr += int'(pwm_out[0]);
            hg += int'(pwm_out[1]);
            hb += int'(pwm_out[2]);
            hl += int'(led_on);
            if (i > 0 && pwm_out[0] && !prev) rr++;
            prev = pwm_out[0];
        end
    endtask

    initial begin
        logic [7:0] d;
        int hr, hg, hb, hl, rr;

        // Reset state
        #12;
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_led", 32'(led_on), 0);
        check("rst_dout", 32'(dout), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            check($sformatf("reset_reg_%0h", a), 32'(d), 0);
        end

        // Basic PWM: DUTYR=0x40, PRESC=0, permanently ON
        wr(4'h0, 8'h40);
        start_exe();
        meas(256, hr, hg, hb, hl, rr);
        check("basic_red_high", hr, 64);
        check("basic_red_rises", rr, 1);
        check("basic_green", hg, 0);
        check("basic_blue", hb, 0);
        check("basic_led_on", hl, 256);

        // Prescale 3 -> 1024-clock period, green full scale, blue zero
        stop_exe();
        wr(4'h3, 8'h03);
        wr(4'h1, 8'hFF);
        wr(4'h2, 8'h00);
        start_exe();
        skip(1100);
        meas(1024, hr, hg, hb, hl, rr);
        check("presc_green_high", hg, 1020);
        check("presc_red_high", hr, 256);
        check("presc_blue", hb, 0);

        // Blink ONR=2, OFR=3: 512 clocks on, 768 off in steady state
        stop_exe();
        wr(4'h3, 8'h00);
        wr(4'h1, 8'h00);
        wr(4'h0, 8'h80);
        wr(4'h5, 8'h02);
        wr(4'h6, 8'h03);
        start_exe();
        skip(1025);
        check("blink_led_1025", 32'(led_on), 0);
        skip(1);
        check("blink_led_1026", 32'(led_on), 1);
        skip(511);
        check("blink_led_1537", 32'(led_on), 1);
        skip(1);
        check("blink_led_1538", 32'(led_on), 0);
        meas(700, hr, hg, hb, hl, rr);
        check("blink_off_red", hr, 0);
        check("blink_off_led", hl, 0);
        rd(4'h8, d);
        check("blink_status_off", 32'(d), 32'h00);
        skip(160);
        rd(4'h8, d);
        check("blink_status_on", 32'(d), 32'h01);
        skip(158);
        meas(256, hr, hg, hb, hl, rr);
        check("blink_on_red", hr, 128);
        check("blink_on_led", hl, 256);

        // Breathe: step 8, ONR=OFR=64, DUTYR=0xFF
        stop_exe();
        wr(4'h0, 8'hFF);
        wr(4'h7, 8'h88);
        wr(4'h5, 8'h40);
        wr(4'h6, 8'h40);
        start_exe();
        meas(256, hr, hg, hb, hl, rr);
        check("breathe_p0", hr, 7);
        meas(256, hr, hg, hb, hl, rr);
        check("breathe_p1", hr, 15);
        skip(256 * 38);
        meas(256, hr, hg, hb, hl, rr);
        check("breathe_p40_sat", hr, 254);
        skip(256 * 22);
        meas(256, hr, hg, hb, hl, rr);
        check("breathe_p63_off", hr, 246);
        meas(256, hr, hg, hb, hl, rr);
        check("breathe_p64_off", hr, 238);
        rd(4'h8, d);
        check("breathe_status", 32'(d), 32'h02);

        // Bus reads and masked fields
        stop_exe();
        wr(4'h1, 8'h5A);
        rd(4'h1, d);
        check("rd_dutyg", 32'(d), 32'h5A);
        wr(4'hA, 8'hFF);
        rd(4'hA, d);
        check("rd_unmapped", 32'(d), 32'h00);
        wr(4'h4, 8'hFF);
        rd(4'h4, d);
        check("rd_presch", 32'(d), 32'h03);
        rd(4'h7, d);
        check("rd_bcr", 32'(d), 32'h88);
        wr(4'h7, 8'hFF);
        rd(4'h7, d);
        check("rd_bcr_mask", 32'(d), 32'h8F);
        wr(4'h4, 8'h00);
        wr(4'h7, 8'h00);

        // Mid-period duty change takes effect at the next boundary
        wr(4'h0, 8'h40);
        wr(4'h5, 8'h00);
        wr(4'h6, 8'h00);
        start_exe();
        meas(100, hr, hg, hb, hl, rr);
        check("mid_p0_head", hr, 64);
        wr(4'h0, 8'hC0);
        meas(154, hr, hg, hb, hl, rr);
        check("mid_p0_tail", hr, 0);
        meas(256, hr, hg, hb, hl, rr);
        check("mid_p1", hr, 192);

        // exe dropped mid-pulse
        skip(50);
        check("exe_pre_pwm", 32'(pwm_out[0]), 1);
        stop_exe();
        skip(1);
        check("exe_off_pwm", 32'(pwm_out), 0);
        check("exe_off_led", 32'(led_on), 0);
        rd(4'h0, d);
        check("exe_keep_dutyr", 32'(d), 32'hC0);
        rd(4'h1, d);
        check("exe_keep_dutyg", 32'(d), 32'h5A);

        // Asynchronous reset mid-operation
        start_exe();
        skip(10);
        check("arst_pre_pwm", 32'(pwm_out[0]), 1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm_out), 0);
        check("arst_led", 32'(led_on), 0);
        check("arst_dout", 32'(dout), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            check($sformatf("arst_reg_%0h", a), 32'(d), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
